// File: rtl/spi_audit_pkg.sv
// Shared types and constants for the SPI frame auditor.
//   state_t     : receiver FSM states
//   err_code_t  : frame error classification
//   ST_*        : status word field positions, counted from the MSB
package spi_audit_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    RECV      = 2'd2,
    CHECK     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CSUM = 2'd2
  } err_code_t;

  localparam int ST_OK_FROM_MSB   = 0;
  localparam int ST_OVER_FROM_MSB = 1;
  localparam int ST_FLAG_BITS     = 2;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchroniser for one asynchronous pin with optional edge detection.
//   i_clk, i_rst : system clock, synchronous active-high reset
//   i_pin        : asynchronous input
//   o_level      : synchronised level (SYNC_STAGES flops)
//   o_rise/o_fall: registered one-cycle edge pulses (0 when EDGE_DET=0)
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_DET    = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_level;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_pin;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_level = r_sync[SYNC_STAGES-1];
  assign o_level = w_level;

  if (EDGE_DET) begin : g_edge
    logic r_prev, r_rise, r_fall;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_prev <= 1'b0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_prev <= w_level;
        r_rise <= w_level & ~r_prev;
        r_fall <= ~w_level & r_prev;
      end
    end
    assign o_rise = r_rise;
    assign o_fall = r_fall;
  end else begin : g_level
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
  end

endmodule

// File: rtl/spi_frame_auditor.sv
// SPI mode-0 slave frame receiver and integrity auditor.
// Receives N_WORDS words of DATA_W bits (last word is an XOR checksum),
// validates length and checksum on CS release, latches good payloads and
// returns a status word on MISO during the following frame.
//   clk_in, rst          : system clock, synchronous active-high reset
//   spi_cs/sck/mosi      : asynchronous SPI pins from the master
//   spi_miso             : status word, 0 outside RECV
//   frame_data           : last good payload, word 0 in the MSBs
//   frame_valid          : one-cycle pulse when frame_data updates
//   integrity_ok/err_code: result of the last completed frame
//   ok_count/err_count   : saturating frame counters
//   over_thresh          : hysteresis flag on payload word 0
//   led                  : active low {!integrity_ok, !over_thresh}
//
// state     | meaning
// WAIT_IDLE | after reset, wait for CS high so a partial frame is not audited
// IDLE      | CS high, waiting for CS fall
// RECV      | CS low, shifting bits in and status out
// CHECK     | one cycle, classify the frame and update results
module spi_frame_auditor
  import spi_audit_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int N_WORDS     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int THRESH_HI   = 30,
  parameter int THRESH_LO   = 28,
  parameter int CNT_W       = 8
) (
  input  logic                          clk_in,
  input  logic                          rst,
  input  logic                          spi_cs,
  input  logic                          spi_sck,
  input  logic                          spi_mosi,
  output logic                          spi_miso,
  output logic [(N_WORDS-1)*DATA_W-1:0] frame_data,
  output logic                          frame_valid,
  output logic                          integrity_ok,
  output logic [1:0]                    err_code,
  output logic [CNT_W-1:0]              ok_count,
  output logic [CNT_W-1:0]              err_count,
  output logic                          over_thresh,
  output logic [1:0]                    led
);

  localparam int TOTAL_BITS = N_WORDS * DATA_W;
  localparam int PAY_W      = (N_WORDS - 1) * DATA_W;
  localparam int BC_W       = $clog2(TOTAL_BITS + 2);
  localparam int WB_W       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int WI_W       = $clog2(N_WORDS + 1);

  localparam logic [BC_W-1:0]   BC_FULL = BC_W'(TOTAL_BITS);
  localparam logic [BC_W-1:0]   BC_SAT  = BC_W'(TOTAL_BITS + 1);
  localparam logic [WB_W-1:0]   WB_LAST = WB_W'(DATA_W - 1);
  localparam logic [WI_W-1:0]   WI_MAX  = WI_W'(N_WORDS);
  localparam logic [DATA_W-1:0] TH_HI   = DATA_W'(THRESH_HI);
  localparam logic [DATA_W-1:0] TH_LO   = DATA_W'(THRESH_LO);

  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_sck_lvl_unused, w_sck_rise, w_sck_fall;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_sync_cs (
    .i_clk(clk_in), .i_rst(rst), .i_pin(spi_cs),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_sync_sck (
    .i_clk(clk_in), .i_rst(rst), .i_pin(spi_sck),
    .o_level(w_sck_lvl_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_sync_mosi (
    .i_clk(clk_in), .i_rst(rst), .i_pin(spi_mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  state_t            r_state, w_state_nxt;
  logic              w_start, w_check, w_shift, w_tx_shift;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [WB_W-1:0]   r_wbit;
  logic [WI_W-1:0]   r_widx;
  logic              r_ovf;
  logic [DATA_W-2:0] r_rx;
  logic [DATA_W-1:0] r_acc, r_tx, w_word, w_status, w_w0;
  logic [PAY_W-1:0]  r_stage, r_frame;
  logic              r_valid, r_ok, r_over;
  err_code_t         r_err;
  logic [CNT_W-1:0]  r_ok_cnt, r_err_cnt;

  always_ff @(posedge clk_in) begin
    if (rst) r_state <= WAIT_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_check     = 1'b0;
    unique case (r_state)
      WAIT_IDLE: if (w_cs_lvl) w_state_nxt = IDLE;
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = RECV;
          w_start     = 1'b1;
        end
      end
      RECV:  if (w_cs_rise) w_state_nxt = CHECK;
      CHECK: begin
        w_state_nxt = IDLE;
        w_check     = 1'b1;
      end
      default: w_state_nxt = WAIT_IDLE;
    endcase
  end

  // SCK edges coinciding with CS release belong to no frame
  assign w_shift    = (r_state == RECV) && w_sck_rise && !w_cs_rise;
  assign w_tx_shift = (r_state == RECV) && w_sck_fall && !w_cs_rise;
  assign w_word     = {r_rx, w_mosi};
  assign w_w0       = r_stage[PAY_W-1 -: DATA_W];

  always_comb begin
    w_status = '0;
    w_status[DATA_W-1-ST_OK_FROM_MSB]   = r_ok;
    w_status[DATA_W-1-ST_OVER_FROM_MSB] = r_over;
    w_status[DATA_W-ST_FLAG_BITS-1:0]   = r_err_cnt[DATA_W-ST_FLAG_BITS-1:0];
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_wbit    <= '0;
      r_widx    <= '0;
      r_ovf     <= 1'b0;
      r_rx      <= '0;
      r_acc     <= '0;
      r_tx      <= '0;
      r_stage   <= '0;
      r_frame   <= '0;
      r_valid   <= 1'b0;
      r_ok      <= 1'b0;
      r_over    <= 1'b0;
      r_err     <= ERR_NONE;
      r_ok_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_start) begin
        r_bit_cnt <= '0;
        r_wbit    <= '0;
        r_widx    <= '0;
        r_acc     <= '0;
        r_ovf     <= 1'b0;
        r_tx      <= w_status;
      end
      if (w_shift) begin
        r_rx <= w_word[DATA_W-2:0];
        if (r_bit_cnt != BC_SAT) begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == BC_FULL) r_ovf <= 1'b1;
        end
        if (r_wbit == WB_LAST) begin
          r_wbit <= '0;
          r_acc  <= r_acc ^ w_word;
          for (int k = 0; k < N_WORDS - 1; k++)
            if (r_widx == WI_W'(k)) r_stage[(N_WORDS-2-k)*DATA_W +: DATA_W] <= w_word;
          if (r_widx != WI_MAX) r_widx <= r_widx + 1'b1;
        end else begin
          r_wbit <= r_wbit + 1'b1;
        end
      end
      // rotating repeats the status word in every word slot
      if (w_tx_shift) r_tx <= {r_tx[DATA_W-2:0], r_tx[DATA_W-1]};
      if (w_check) begin
        if ((r_bit_cnt != BC_FULL) || r_ovf) begin
          r_err <= ERR_LEN;
          r_ok  <= 1'b0;
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
        end else if (r_acc != '0) begin
          r_err <= ERR_CSUM;
          r_ok  <= 1'b0;
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
        end else begin
          r_frame <= r_stage;
          r_valid <= 1'b1;
          r_ok    <= 1'b1;
          r_err   <= ERR_NONE;
          if (r_ok_cnt != '1) r_ok_cnt <= r_ok_cnt + 1'b1;
          if (w_w0 > TH_HI)      r_over <= 1'b1;
          else if (w_w0 < TH_LO) r_over <= 1'b0;
        end
      end
    end
  end

  assign spi_miso     = (r_state == RECV) ? r_tx[DATA_W-1] : 1'b0;
  assign frame_data   = r_frame;
  assign frame_valid  = r_valid;
  assign integrity_ok = r_ok;
  assign err_code     = r_err;
  assign ok_count     = r_ok_cnt;
  assign err_count    = r_err_cnt;
  assign over_thresh  = r_over;
  assign led          = {~r_ok, ~r_over};

endmodule

// File: tb/tb_spi_frame_auditor.sv
// Directed bench for spi_frame_auditor with default parameters
// (DATA_W=8, N_WORDS=3, SYNC_STAGES=2, thresholds 30/28, CNT_W=8).
module tb_spi_frame_auditor;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        spi_cs = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        integrity_ok;
  logic [1:0]  err_code;
  logic [7:0]  ok_count;
  logic [7:0]  err_count;
  logic        over_thresh;
  logic [1:0]  led;

  int total = 0;
  int bad = 0;
  int valid_cnt = 0;
  int v0;

  spi_frame_auditor dut (
    .clk_in(clk_in), .rst(rst), .spi_cs(spi_cs), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .frame_data(frame_data),
    .frame_valid(frame_valid), .integrity_ok(integrity_ok), .err_code(err_code),
    .ok_count(ok_count), .err_count(err_count), .over_thresh(over_thresh), .led(led)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) if (frame_valid === 1'b1) valid_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] val, input int n,
                           input bit chk_miso, input logic [7:0] st);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = val[i];
      tick(8);
      spi_sck = 1'b1;
      if (chk_miso) check_val("miso", {31'b0, spi_miso}, {31'b0, st[7 - ((n - 1 - i) % 8)]});
      tick(8);
      spi_sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] val, input int n,
                       input bit chk_miso, input logic [7:0] st);
    spi_cs = 1'b0;
    tick(8);
    send_bits(val, n, chk_miso, st);
    tick(8);
    spi_cs = 1'b1;
    tick(12);
  endtask

  function automatic logic [31:0] mk3(input logic [7:0] w0, input logic [7:0] w1);
    return {8'h00, w0, w1, w0 ^ w1};
  endfunction

  int         hys_w0  [9] = '{29, 27, 31, 30, 28, 27, 28, 30, 31};
  logic [0:0] hys_exp [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    tick(5);
    check_val("rst_frame_data", {16'b0, frame_data}, 32'h0);
    check_val("rst_valid", {31'b0, frame_valid}, 32'h0);
    check_val("rst_ok", {31'b0, integrity_ok}, 32'h0);
    check_val("rst_err_code", {30'b0, err_code}, 32'h0);
    check_val("rst_counts", {16'b0, ok_count, err_count}, 32'h0);
    check_val("rst_over", {31'b0, over_thresh}, 32'h0);
    check_val("rst_led", {30'b0, led}, 32'h3);
    check_val("rst_miso", {31'b0, spi_miso}, 32'h0);
    rst = 1'b0;
    tick(10);

    // good frame, word 0 = 0x23 (35 > 30)
    v0 = valid_cnt;
    frame(32'h0023_1033, 24, 1'b1, 8'h00);
    check_val("good_data", {16'b0, frame_data}, 32'h2310);
    check_val("good_valid", valid_cnt - v0, 1);
    check_val("good_okcnt", {24'b0, ok_count}, 1);
    check_val("good_ok", {31'b0, integrity_ok}, 1);
    check_val("good_over", {31'b0, over_thresh}, 1);
    check_val("good_led", {30'b0, led}, 32'h0);
    check_val("good_err", {30'b0, err_code}, 0);

    // checksum error
    v0 = valid_cnt;
    frame(32'h0023_1032, 24, 1'b1, 8'hC0);
    check_val("csum_err", {30'b0, err_code}, 2);
    check_val("csum_errcnt", {24'b0, err_count}, 1);
    check_val("csum_data", {16'b0, frame_data}, 32'h2310);
    check_val("csum_led", {30'b0, led}, 32'h2);
    check_val("csum_ok", {31'b0, integrity_ok}, 0);
    check_val("csum_valid", valid_cnt - v0, 0);

    // short and long frames
    v0 = valid_cnt;
    frame(32'h0011_8819, 23, 1'b1, 8'h41);
    check_val("short_err", {30'b0, err_code}, 1);
    check_val("short_errcnt", {24'b0, err_count}, 2);
    frame(32'h0046_2067, 25, 1'b1, 8'h42);
    check_val("long_err", {30'b0, err_code}, 1);
    check_val("long_errcnt", {24'b0, err_count}, 3);
    check_val("len_valid", valid_cnt - v0, 0);
    check_val("len_data", {16'b0, frame_data}, 32'h2310);

    // hysteresis sequence including both threshold boundaries
    for (int k = 0; k < 9; k++) begin
      frame(mk3(8'(hys_w0[k]), 8'h00), 24, 1'b0, 8'h00);
      check_val("hyst", {31'b0, over_thresh}, {31'b0, hys_exp[k]});
    end
    check_val("hyst_data", {16'b0, frame_data}, 32'h1F00);
    check_val("hyst_okcnt", {24'b0, ok_count}, 10);

    // reset in the middle of a frame
    v0 = valid_cnt;
    spi_cs = 1'b0;
    tick(8);
    send_bits(32'h0000_0231, 12, 1'b0, 8'h00);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    send_bits(32'h0000_0033, 12, 1'b0, 8'h00);
    tick(8);
    spi_cs = 1'b1;
    tick(12);
    check_val("abort_counts", {16'b0, ok_count, err_count}, 0);
    check_val("abort_valid", valid_cnt - v0, 0);
    check_val("abort_data", {16'b0, frame_data}, 0);
    check_val("abort_led", {30'b0, led}, 32'h3);

    frame(mk3(8'h05, 8'h07), 24, 1'b0, 8'h00);
    check_val("post_okcnt", {24'b0, ok_count}, 1);
    check_val("post_data", {16'b0, frame_data}, 32'h0507);
    check_val("post_over", {31'b0, over_thresh}, 0);

    // zero-bit frame, then MISO must carry 0x01
    frame(32'h0, 0, 1'b0, 8'h00);
    check_val("zero_err", {30'b0, err_code}, 1);
    check_val("zero_errcnt", {24'b0, err_count}, 1);
    frame(mk3(8'h05, 8'h07), 24, 1'b1, 8'h01);
    check_val("miso_okcnt", {24'b0, ok_count}, 2);

    // saturate the error counter
    for (int k = 0; k < 254; k++) frame(32'h0, 0, 1'b0, 8'h00);
    check_val("sat_reach", {24'b0, err_count}, 255);
    frame(32'h0, 0, 1'b0, 8'h00);
    check_val("sat_hold", {24'b0, err_count}, 255);
    check_val("sat_okcnt", {24'b0, ok_count}, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
